// File: rtl/aclk_controller.sv
// rtl/aclk_controller.sv - alarm clock keypad/button controller: Moore FSM with key-entry timeout.
// Outputs decode only from the state register; a 0..9 seconds counter times out idle key entry.
module aclk_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic [3:0] key,
    output logic       load_new_a,
    output logic       show_a,
    output logic       show_new_time,
    output logic       load_new_c,
    output logic       shift
);

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       is_digit;
    logic       timeout;
    logic       in_entry_q;
    logic       in_entry_d;

    assign is_digit   = (key <= 4'd9);
    assign timeout    = one_second && (count_q == 4'd9);
    assign in_entry_q = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    assign in_entry_d = (state_d == KEY_WAITED) || (state_d == KEY_ENTRY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SHOW_TIME;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME: begin
                if (alarm_button)  state_d = SHOW_ALARM;
                else if (is_digit) state_d = KEY_STORED;
            end
            SHOW_ALARM: begin
                if (!alarm_button) state_d = SHOW_TIME;
            end
            KEY_STORED: state_d = KEY_WAITED;
            KEY_WAITED: begin
                if (!is_digit)     state_d = KEY_ENTRY;
                else if (timeout)  state_d = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button)      state_d = SET_ALARM_TIME;
                else if (time_button)  state_d = SET_CURRENT_TIME;
                else if (timeout)      state_d = SHOW_TIME;
                else if (is_digit)     state_d = KEY_STORED;
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    // Saturating at 9 keeps a strobe swallowed by a key release in KEY_WAITED
    // from wrapping; the next strobe in KEY_ENTRY then times out.
    always_comb begin
        count_d = 4'd0;
        if (in_entry_q && in_entry_d) begin
            if (one_second && (count_q != 4'd9)) count_d = count_q + 4'd1;
            else                                 count_d = count_q;
        end
    end

    always_comb begin
        load_new_a    = 1'b0;
        show_a        = 1'b0;
        show_new_time = 1'b0;
        load_new_c    = 1'b0;
        shift         = 1'b0;
        case (state_q)
            SHOW_ALARM:       show_a = 1'b1;
            KEY_STORED: begin
                shift         = 1'b1;
                show_new_time = 1'b1;
            end
            KEY_WAITED:       show_new_time = 1'b1;
            KEY_ENTRY:        show_new_time = 1'b1;
            SET_ALARM_TIME:   load_new_a = 1'b1;
            SET_CURRENT_TIME: load_new_c = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aclk_controller.sv
// tb/tb_aclk_controller.sv - self-checking bench for aclk_controller against a behavioural model.
module tb_aclk_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic [3:0] key = 4'd10;
    logic       load_new_a, show_a, show_new_time, load_new_c, shift;

    aclk_controller dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .key           (key),
        .load_new_a    (load_new_a),
        .show_a        (show_a),
        .show_new_time (show_new_time),
        .load_new_c    (load_new_c),
        .shift         (shift)
    );

    always #5 clock = ~clock;

    localparam int M_IDLE   = 0;
    localparam int M_ALARM  = 1;
    localparam int M_SHIFT  = 2;
    localparam int M_HOLD   = 3;
    localparam int M_ENTRY  = 4;
    localparam int M_LOAD_A = 5;
    localparam int M_LOAD_C = 6;

    int checks = 0;
    int failures = 0;
    int m_mode = M_IDLE;
    int m_strobes = 0;
    int shift_cnt, load_a_cnt, load_c_cnt, show_a_cnt;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {load_new_a, show_a, show_new_time, load_new_c, shift}
    function automatic logic [4:0] model_outputs(input int mode);
        case (mode)
            M_ALARM:  return 5'b01000;
            M_SHIFT:  return 5'b00101;
            M_HOLD:   return 5'b00100;
            M_ENTRY:  return 5'b00100;
            M_LOAD_A: return 5'b10000;
            M_LOAD_C: return 5'b00010;
            default:  return 5'b00000;
        endcase
    endfunction

    task automatic model_step();
        bit digit   = (key <= 4'd9);
        bit expired = one_second && (m_strobes >= 9);
        int nxt     = m_mode;
        case (m_mode)
            M_IDLE:  if (alarm_button) nxt = M_ALARM; else if (digit) nxt = M_SHIFT;
            M_ALARM: if (!alarm_button) nxt = M_IDLE;
            M_SHIFT: nxt = M_HOLD;
            M_HOLD:  if (!digit) nxt = M_ENTRY; else if (expired) nxt = M_IDLE;
            M_ENTRY: begin
                if (alarm_button)     nxt = M_LOAD_A;
                else if (time_button) nxt = M_LOAD_C;
                else if (expired)     nxt = M_IDLE;
                else if (digit)       nxt = M_SHIFT;
            end
            default: nxt = M_IDLE;
        endcase
        if ((nxt == M_HOLD || nxt == M_ENTRY) && (m_mode == M_HOLD || m_mode == M_ENTRY))
            m_strobes += one_second ? 1 : 0;
        else
            m_strobes = 0;
        m_mode = nxt;
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        if (reset) begin
            m_mode = M_IDLE;
            m_strobes = 0;
        end else begin
            model_step();
        end
        #1;
        expect_eq(tag, {load_new_a, show_a, show_new_time, load_new_c, shift}, model_outputs(m_mode));
        shift_cnt  += shift;
        load_a_cnt += load_new_a;
        load_c_cnt += load_new_c;
        show_a_cnt += show_a;
    endtask

    task automatic apply(input logic [3:0] k, input logic ab, input logic tb, input logic os,
                         input int n, input string tag);
        key = k; alarm_button = ab; time_button = tb; one_second = os;
        repeat (n) cycle(tag);
    endtask

    task automatic do_reset();
        key = 4'd10; alarm_button = 0; time_button = 0; one_second = 0;
        reset = 1;
        cycle("reset_hold");
        reset = 0;
        shift_cnt = 0; load_a_cnt = 0; load_c_cnt = 0; show_a_cnt = 0;
    endtask

    task automatic enter_digit(input logic [3:0] d, input string tag);
        apply(d, 0, 0, 0, 2, tag);
        apply(4'd10, 0, 0, 0, 2, tag);
    endtask

    initial begin
        #1;
        expect_eq("async_reset_outputs", {load_new_a, show_a, show_new_time, load_new_c, shift}, 5'b0);
        do_reset();

        // Time set: 1,0,3,0 then time_button
        enter_digit(4'd1, "time_d"); enter_digit(4'd0, "time_d");
        enter_digit(4'd3, "time_d"); enter_digit(4'd0, "time_d");
        apply(4'd10, 0, 1, 0, 1, "time_load");
        apply(4'd10, 0, 0, 0, 2, "time_done");
        expect_eq("time_shift_count", shift_cnt, 4);
        expect_eq("time_load_c_count", load_c_cnt, 1);
        expect_eq("time_load_a_count", load_a_cnt, 0);

        // Alarm set: 1,5,0,0 then alarm_button
        do_reset();
        enter_digit(4'd1, "alm_d"); enter_digit(4'd5, "alm_d");
        enter_digit(4'd0, "alm_d"); enter_digit(4'd0, "alm_d");
        apply(4'd10, 1, 0, 0, 1, "alm_load");
        apply(4'd10, 0, 0, 0, 2, "alm_done");
        expect_eq("alm_load_a_count", load_a_cnt, 1);
        expect_eq("alm_load_c_count", load_c_cnt, 0);
        expect_eq("alm_shift_count", shift_cnt, 4);

        // Alarm show: button held 5 cycles with a digit pressed meanwhile
        do_reset();
        apply(4'd5, 1, 1, 1, 5, "show_alarm");
        apply(4'd10, 0, 0, 0, 2, "show_alarm_rel");
        expect_eq("show_a_count", show_a_cnt, 5);
        expect_eq("show_alarm_shift", shift_cnt, 0);

        // Timeout: 10th strobe returns to SHOW_TIME without any load
        do_reset();
        apply(4'd3, 0, 0, 0, 2, "to_digit");
        apply(4'd10, 0, 0, 0, 1, "to_release");
        apply(4'd10, 0, 0, 1, 9, "to_strobes9");
        expect_eq("to_still_entry", show_new_time, 1'b1);
        apply(4'd10, 0, 0, 1, 1, "to_strobe10");
        expect_eq("to_back_idle", show_new_time, 1'b0);
        expect_eq("to_no_load", load_a_cnt + load_c_cnt, 0);

        // Digit after the 9th strobe restarts the count
        do_reset();
        apply(4'd3, 0, 0, 0, 2, "rs_digit");
        apply(4'd10, 0, 0, 0, 1, "rs_release");
        apply(4'd10, 0, 0, 1, 9, "rs_strobes9");
        apply(4'd7, 0, 0, 0, 2, "rs_digit2");
        apply(4'd10, 0, 0, 0, 1, "rs_release2");
        apply(4'd10, 0, 0, 1, 9, "rs_strobes9b");
        expect_eq("rs_still_entry", show_new_time, 1'b1);
        apply(4'd10, 0, 0, 1, 1, "rs_strobe10");
        expect_eq("rs_back_idle", show_new_time, 1'b0);

        // Both buttons in KEY_ENTRY: alarm wins
        do_reset();
        enter_digit(4'd9, "both_d");
        apply(4'd10, 1, 1, 0, 1, "both_press");
        expect_eq("both_load_a", load_new_a, 1'b1);
        expect_eq("both_load_c", load_new_c, 1'b0);
        apply(4'd10, 0, 0, 0, 2, "both_done");

        // Asynchronous reset while in KEY_WAITED
        do_reset();
        apply(4'd4, 0, 0, 0, 2, "ar_wait");
        expect_eq("ar_before", show_new_time, 1'b1);
        #2 reset = 1;
        #1 expect_eq("ar_outputs_zero", {load_new_a, show_a, show_new_time, load_new_c, shift}, 5'b0);
        cycle("ar_held");
        key = 4'd10;
        reset = 0;
        cycle("ar_after");

        // Random phases: busy mixed inputs, then strobe-heavy with sparse keys
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                int hold = $urandom_range(1, 4);
                key          = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(10, 15)) :
                               ((ph == 1 && $urandom_range(0, 3) != 0) ? 4'd10 : 4'($urandom_range(0, 9)));
                alarm_button = ($urandom_range(0, 9) == 0);
                time_button  = ($urandom_range(0, 9) == 0);
                one_second   = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0);
                reset        = ($urandom_range(0, 199) == 0);
                repeat (hold) cycle("random");
            end
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aclk_controller.md
ACLK_CONTROLLER -- requirements
Module: aclk_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; forces the reset state immediately, independent of clock.
REQ-003 SHALL have port one_second, input, 1 bit: one-clock-wide strobe, once per second.
REQ-004 SHALL have port alarm_button, input, 1 bit: level, high while the alarm button is held.
REQ-005 SHALL have port time_button, input, 1 bit: level, high while the time button is held.
REQ-006 SHALL have port key, input, 4 bits: 0-9 = digit pressed; 10 (NOKEY) = no key; 11-15 treated as NOKEY.
REQ-007 SHALL have port load_new_a, output, 1 bit: load key register into the alarm-time register.
REQ-008 SHALL have port show_a, output, 1 bit: display selects alarm time; drives display show_a.
REQ-009 SHALL have port show_new_time, output, 1 bit: display selects key-entry digits.
REQ-010 SHALL have port load_new_c, output, 1 bit: load key register into the current-time counter.
REQ-011 SHALL have port shift, output, 1 bit: shift the key register left one digit and insert key.

Function
REQ-012 SHALL implement a Moore FSM with 7 states: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME.
REQ-013 SHALL decode all outputs from the state register only, so each output is valid in the cycle its state is occupied, with no input-to-output combinational path.
REQ-014 SHALL drive outputs per state: SHOW_ALARM -> show_a=1; KEY_STORED -> shift=1 and show_new_time=1; KEY_WAITED and KEY_ENTRY -> show_new_time=1; SET_ALARM_TIME -> load_new_a=1; SET_CURRENT_TIME -> load_new_c=1; all other outputs 0.
REQ-015 SHALL transition from SHOW_TIME: alarm_button=1 -> SHOW_ALARM; else key digit -> KEY_STORED; else stay. alarm_button SHALL win when it coincides with a digit.
REQ-016 SHALL transition from SHOW_ALARM: alarm_button=0 -> SHOW_TIME; else stay. key and time_button SHALL be ignored in SHOW_ALARM.
REQ-017 SHALL transition from KEY_STORED -> KEY_WAITED unconditionally, so shift is exactly 1 cycle per keypress.
REQ-018 SHALL transition from KEY_WAITED: key=NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay. A held key SHALL produce no further shift.
REQ-019 SHALL transition from KEY_ENTRY with priority alarm_button -> SET_ALARM_TIME, then time_button -> SET_CURRENT_TIME, then timeout -> SHOW_TIME, then key digit -> KEY_STORED; else stay.
REQ-020 SHALL transition from SET_ALARM_TIME and SET_CURRENT_TIME -> SHOW_TIME unconditionally, so each load pulse is exactly 1 cycle.
REQ-021 SHALL keep a 4-bit seconds counter that increments on one_second while in KEY_WAITED or KEY_ENTRY, and is cleared to 0 in every other state.
REQ-022 SHALL assert timeout when counter==9 and one_second=1, which is the 10th strobe after entering KEY_WAITED; the counter SHALL never exceed 9 and SHALL clear when KEY_STORED is re-entered.
REQ-023 SHALL not retain partial digits on timeout; the key register contents are left to the datapath, and the controller only returns to SHOW_TIME.

Reset
REQ-024 SHALL, while reset=1, hold state=SHOW_TIME, counter=0, and all five outputs 0.
REQ-025 SHALL, on reset asserted mid-entry (any state), abort to SHOW_TIME within the same cycle with no load pulse issued.
REQ-026 SHALL leave SHOW_TIME on the first rising edge after reset deasserts only if a REQ-015 condition holds.

Verification
REQ-027 SHALL cover digit entry: key 1,NOKEY,0,NOKEY,3,NOKEY,0,NOKEY then time_button=1 -> exactly 4 one-cycle shift pulses, then one load_new_c pulse, then SHOW_TIME.
REQ-028 SHALL cover alarm set: key sequence 1,5,0,0 (each released) then alarm_button=1 -> exactly 1 load_new_a pulse, and load_new_c stays 0.
REQ-029 SHALL cover alarm show: alarm_button held 5 cycles from SHOW_TIME -> show_a=1 for 5 cycles, and a digit pressed meanwhile causes no shift.
REQ-030 SHALL cover timeout: one digit then idle with 10 one_second strobes -> SHOW_TIME on the 10th strobe with no load pulse; a digit after the 9th strobe restarts the count.
REQ-031 SHALL cover simultaneous buttons: alarm_button=time_button=1 in KEY_ENTRY -> load_new_a=1 and load_new_c=0.
REQ-032 SHALL cover reset: reset pulsed asynchronously in KEY_WAITED -> outputs 0 and state SHOW_TIME before the next clock edge.
